// File: rtl/maze_explorer.sv
// Depth-first maze explorer: walks a 16x16 grid from (0,0) to the goal and backtracks on dead ends.
// Optional PATH_TRACE_EN adds trace_valid/trace_dir and replays the found path before DONE.
module maze_explorer #(
    parameter int unsigned GRID_MAX    = 15,
    parameter int unsigned GOAL_ROW    = 15,
    parameter int unsigned GOAL_COL    = 15,
    parameter int unsigned STACK_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] row,
    output logic [7:0] colomn,
    output logic       mem_rd,
    input  logic       dout,
    output logic       mem_wr,
    output logic       mem_din,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic       overflow,
`ifdef PATH_TRACE_EN
    output logic       trace_valid,
    output logic [1:0] trace_dir,
`endif
    output logic [8:0] path_len
);

    localparam int unsigned SpW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [8:0]  DEPTH  = 9'(STACK_DEPTH);
    localparam logic [7:0]  GMAX   = 8'(GRID_MAX);
    localparam logic [7:0]  GOAL_R = 8'(GOAL_ROW);
    localparam logic [7:0]  GOAL_C = 8'(GOAL_COL);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] MARK  = 4'd1;
    localparam logic [3:0] PROBE = 4'd2;
    localparam logic [3:0] WAIT  = 4'd3;
    localparam logic [3:0] NEXT  = 4'd4;
    localparam logic [3:0] POP   = 4'd5;
    localparam logic [3:0] DONE  = 4'd6;
    localparam logic [3:0] FAIL  = 4'd7;
    localparam logic [3:0] TRACE = 4'd8;

    logic [3:0] state_q, state_d;
    logic [7:0] cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    logic [1:0] dir_q, dir_d;
    logic [8:0] sp_q, sp_d;
    logic       done_q, done_d, fail_q, fail_d, ovf_q, ovf_d;
    logic [7:0] row_q, col_q;
    logic       push;

    logic [1:0] stack [STACK_DEPTH];

    logic [7:0] cand_row, cand_col, back_row, back_col;
    logic       cand_oob, at_goal;
    logic [1:0] pop_dir;
    logic [SpW-1:0] top_idx;

`ifdef PATH_TRACE_EN
    logic [8:0] trace_idx_q, trace_idx_d;
`endif

    assign top_idx  = sp_q[SpW-1:0] - SpW'(1);
    assign pop_dir  = stack[top_idx];
    assign at_goal  = (cur_row_q == GOAL_R) && (cur_col_q == GOAL_C);
    // 0-1 wraps to 8'hFF, so a single upper-bound compare also catches underflow
    assign cand_oob = (cand_row > GMAX) || (cand_col > GMAX);

    always_comb begin
        cand_row = cur_row_q;
        cand_col = cur_col_q;
        case (dir_q)
            2'd0:    cand_col = cur_col_q + 8'd1;
            2'd1:    cand_row = cur_row_q + 8'd1;
            2'd2:    cand_col = cur_col_q - 8'd1;
            default: cand_row = cur_row_q - 8'd1;
        endcase
    end

    // Undo the move recorded on top of the stack
    always_comb begin
        back_row = cur_row_q;
        back_col = cur_col_q;
        case (pop_dir)
            2'd0:    back_col = cur_col_q - 8'd1;
            2'd1:    back_row = cur_row_q - 8'd1;
            2'd2:    back_col = cur_col_q + 8'd1;
            default: back_row = cur_row_q + 8'd1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        dir_d     = dir_q;
        sp_d      = sp_q;
        done_d    = done_q;
        fail_d    = fail_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
`ifdef PATH_TRACE_EN
        trace_idx_d = trace_idx_q;
`endif
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_d   = MARK;
                    cur_row_d = 8'd0;
                    cur_col_d = 8'd0;
                    sp_d      = 9'd0;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    ovf_d     = 1'b0;
                end
            end
            MARK: begin
                if (at_goal) begin
`ifdef PATH_TRACE_EN
                    if (sp_q == 9'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = TRACE;
                        trace_idx_d = 9'd0;
                    end
`else
                    state_d = DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    dir_d   = 2'd0;
                    state_d = PROBE;
                end
            end
            PROBE: state_d = cand_oob ? NEXT : WAIT;
            WAIT: begin
                if (dout) begin
                    state_d = NEXT;
                end else if (sp_q == DEPTH) begin
                    state_d = FAIL;
                    fail_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    push      = 1'b1;
                    sp_d      = sp_q + 9'd1;
                    cur_row_d = cand_row;
                    cur_col_d = cand_col;
                    state_d   = MARK;
                end
            end
            NEXT: begin
                if (dir_q != 2'd3) begin
                    dir_d   = dir_q + 2'd1;
                    state_d = PROBE;
                end else begin
                    state_d = POP;
                end
            end
            POP: begin
                if (sp_q == 9'd0) begin
                    state_d = FAIL;
                    fail_d  = 1'b1;
                end else begin
                    sp_d      = sp_q - 9'd1;
                    cur_row_d = back_row;
                    cur_col_d = back_col;
                    if (pop_dir != 2'd3) begin
                        dir_d   = pop_dir + 2'd1;
                        state_d = PROBE;
                    end else begin
                        dir_d   = 2'd3;
                        state_d = NEXT;
                    end
                end
            end
`ifdef PATH_TRACE_EN
            TRACE: begin
                if (trace_idx_q == sp_q - 9'd1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    trace_idx_d = trace_idx_q + 9'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_wr  = (state_q == MARK);
        mem_rd  = (state_q == PROBE) && !cand_oob;
        mem_din = mem_wr;
        row     = row_q;
        colomn  = col_q;
        if (mem_wr) begin
            row    = cur_row_q;
            colomn = cur_col_q;
        end else if (mem_rd) begin
            row    = cand_row;
            colomn = cand_col;
        end
    end

    always_comb begin
        busy = 1'b0;
        case (state_q)
            MARK, PROBE, WAIT, NEXT, POP, TRACE: busy = 1'b1;
            default:                             busy = 1'b0;
        endcase
    end

    assign done     = done_q;
    assign fail     = fail_q;
    assign overflow = ovf_q;
    assign path_len = sp_q;

`ifdef PATH_TRACE_EN
    assign trace_valid = (state_q == TRACE);
    assign trace_dir   = trace_valid ? stack[trace_idx_q[SpW-1:0]] : 2'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_row_q <= 8'd0;
            cur_col_q <= 8'd0;
            dir_q     <= 2'd0;
            sp_q      <= 9'd0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            ovf_q     <= 1'b0;
            row_q     <= 8'd0;
            col_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            dir_q     <= dir_d;
            sp_q      <= sp_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            ovf_q     <= ovf_d;
            row_q     <= row;
            col_q     <= colomn;
        end
    end

`ifdef PATH_TRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_idx_q <= 9'd0;
        end else begin
            trace_idx_q <= trace_idx_d;
        end
    end
`endif

    // Stack storage needs no reset: sp alone decides which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp_q[SpW-1:0]] <= dir_q;
        end
    end

endmodule
